// File: rtl/fpu_div16.sv
// Iterative IEEE-754 binary16 divider (fpuIn1 / fpuIn2), radix-2 restoring,
// one quotient bit per cycle, fixed latency for every operand class.
module fpu_div16 #(
  parameter int QBITS = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic [15:0] fpuOut,
  output logic        done,
  output logic [3:0]  condCodes,
  output logic [4:0]  opStatusFlags
);

  localparam int CW = $clog2(QBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [6:0]  exp_q, exp_d;
  logic [10:0]        sig2_q, sig2_d;
  logic [12:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic               spec_q, spec_d;
  logic [15:0]        spec_res_q, spec_res_d;
  logic [4:0]         spec_flags_q, spec_flags_d;
  logic [15:0]        out_q, out_d;
  logic [4:0]         flags_q, flags_d;
  logic [3:0]         cc_q, cc_d;

  // Operand classification; subnormals count as zero (flush-to-zero).
  logic [4:0] e1, e2;
  logic [9:0] m1, m2;
  logic       zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2;

  assign e1    = a_q[14:10];
  assign m1    = a_q[9:0];
  assign e2    = b_q[14:10];
  assign m2    = b_q[9:0];
  assign zero1 = (e1 == 5'd0);
  assign zero2 = (e2 == 5'd0);
  assign inf1  = (e1 == 5'h1F) && (m1 == 10'd0);
  assign inf2  = (e2 == 5'h1F) && (m2 == 10'd0);
  assign nan1  = (e1 == 5'h1F) && (m1 != 10'd0);
  assign nan2  = (e2 == 5'h1F) && (m2 != 10'd0);
  assign snan1 = nan1 && !m1[9];
  assign snan2 = nan2 && !m2[9];

  logic [13:0] diff;
  logic        q_bit;
  logic [12:0] rem_sub;

  assign diff    = {1'b0, rem_q} - {3'b000, sig2_q};
  assign q_bit   = ~diff[13];
  assign rem_sub = q_bit ? diff[12:0] : rem_q;

  logic [9:0]        mant;
  logic              guard, sticky, round_up;
  logic [10:0]       mant_r;
  logic signed [6:0] exp_r;

  assign mant     = quo_q[QBITS-2 -: 10];
  assign guard    = quo_q[QBITS-12];
  assign sticky   = (|quo_q[QBITS-13:0]) | (rem_q != 13'd0);
  assign round_up = guard & (sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {10'd0, round_up};
  assign exp_r    = exp_q + $signed({6'd0, mant_r[10]});

  // Final packing of the rounded result, including overflow/underflow.
  logic [15:0] res;
  logic [4:0]  res_flags;
  logic        res_nan;

  always_comb begin
    res       = 16'h0000;
    res_flags = 5'b00000;
    if (spec_q) begin
      res       = spec_res_q;
      res_flags = spec_flags_q;
    end else if (exp_r >= 7'sd31) begin
      res       = {sign_q, 5'h1F, 10'd0};
      res_flags = 5'b00101;
    end else if (exp_r <= 7'sd0) begin
      res       = {sign_q, 15'd0};
      res_flags = 5'b00011;
    end else begin
      res       = {sign_q, exp_r[4:0], mant_r[9:0]};
      res_flags = {4'b0000, guard | sticky};
    end
  end

  assign res_nan = (res[14:10] == 5'h1F) && (res[9:0] != 10'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    sig2_d       = sig2_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    out_d        = out_q;
    flags_d      = flags_q;
    cc_d         = cc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = fpuIn1;
          b_d     = fpuIn2;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d       = a_q[15] ^ b_q[15];
        exp_d        = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 7'sd15;
        rem_d        = {2'b00, 1'b1, m1};
        sig2_d       = {1'b1, m2};
        quo_d        = '0;
        cnt_d        = '0;
        spec_d       = 1'b1;
        spec_res_d   = 16'h7E00;
        spec_flags_d = 5'b00000;
        // Special operands still run the full divide so latency never varies.
        if (nan1 || nan2) begin
          spec_flags_d = {snan1 | snan2, 4'b0000};
        end else if ((zero1 && zero2) || (inf1 && inf2)) begin
          spec_flags_d = 5'b10000;
        end else if (inf1) begin
          spec_res_d = {a_q[15] ^ b_q[15], 5'h1F, 10'd0};
        end else if (zero2) begin
          spec_res_d   = {a_q[15] ^ b_q[15], 5'h1F, 10'd0};
          spec_flags_d = 5'b01000;
        end else if (inf2 || zero1) begin
          spec_res_d = {a_q[15] ^ b_q[15], 15'd0};
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_DIVIDE;
      end

      S_DIVIDE: begin
        quo_d = {quo_q[QBITS-2:0], q_bit};
        rem_d = {rem_sub[11:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QBITS - 1)) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (!quo_q[QBITS-1]) begin
          quo_d = {quo_q[QBITS-2:0], 1'b0};
          exp_d = exp_q - 7'sd1;
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        out_d   = res;
        flags_d = res_flags;
        cc_d    = {res[14:0] == 15'd0, res[15] & ~res_nan, 1'b0, res_flags[2]};
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      sign_q       <= 1'b0;
      exp_q        <= 7'sd0;
      sig2_q       <= 11'd0;
      rem_q        <= 13'd0;
      quo_q        <= '0;
      spec_q       <= 1'b0;
      spec_res_q   <= 16'h0000;
      spec_flags_q <= 5'b00000;
      out_q        <= 16'h0000;
      flags_q      <= 5'b00000;
      cc_q         <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      sig2_q       <= sig2_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      out_q        <= out_d;
      flags_q      <= flags_d;
      cc_q         <= cc_d;
    end
  end

  assign fpuOut        = out_q;
  assign done          = (state_q == S_DONE);
  assign condCodes     = cc_q;
  assign opStatusFlags = flags_q;

endmodule

// File: tb/tb_fpu_div16.sv
// Directed and randomised bench for fpu_div16; random pairs are checked
// against a real-valued reference with round-to-nearest-even and flush-to-zero.
module tb_fpu_div16;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic [15:0] fpuOut;
  logic        done;
  logic [3:0]  condCodes;
  logic [4:0]  opStatusFlags;

  int error_count = 0;
  int check_count = 0;

  fpu_div16 dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .fpuIn1        (fpuIn1),
    .fpuIn2        (fpuIn2),
    .fpuOut        (fpuOut),
    .done          (done),
    .condCodes     (condCodes),
    .opStatusFlags (opStatusFlags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;
    logic [3:0]  cc;
  } vec_t;

  // Flags are {invalid, divByZero, overflow, underflow, inexact}; cc is {Z,N,C,V}.
  localparam int NVEC = 19;
  vec_t vecs [NVEC] = '{
    '{16'h3C00, 16'h4000, 16'h3800, 5'h00, 4'h0},
    '{16'h4200, 16'h4000, 16'h3E00, 5'h00, 4'h0},
    '{16'h3C00, 16'h4200, 16'h3555, 5'h01, 4'h0},
    '{16'hC000, 16'h3C00, 16'hC000, 5'h00, 4'h4},
    '{16'h0000, 16'h0000, 16'h7E00, 5'h10, 4'h0},
    '{16'h4000, 16'h0000, 16'h7C00, 5'h08, 4'h0},
    '{16'h7C00, 16'h7C00, 16'h7E00, 5'h10, 4'h0},
    '{16'h3C00, 16'h7C00, 16'h0000, 5'h00, 4'h8},
    '{16'h7BFF, 16'h3800, 16'h7C00, 5'h05, 4'h1},
    '{16'h0400, 16'h7BFF, 16'h0000, 5'h03, 4'h8},
    '{16'h7C01, 16'h3C00, 16'h7E00, 5'h10, 4'h0},
    '{16'h7E00, 16'h3C00, 16'h7E00, 5'h00, 4'h0},
    '{16'hFC00, 16'h4000, 16'hFC00, 5'h00, 4'h4},
    '{16'h3C00, 16'hFC00, 16'h8000, 5'h00, 4'hC},
    '{16'h0001, 16'h3C00, 16'h0000, 5'h00, 4'h8},
    '{16'h3C00, 16'h0001, 16'h7C00, 5'h08, 4'h0},
    '{16'h4200, 16'h4500, 16'h38CD, 5'h01, 4'h0},
    '{16'h3C00, 16'h4500, 16'h3266, 5'h01, 4'h0},
    '{16'h7C00, 16'h7D00, 16'h7E00, 5'h10, 4'h0}
  };

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles the operands right after acceptance and
  // returns the number of edges until done (or -1 if it never came).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clock);
    fpuIn1 = a;
    fpuIn2 = b;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    fpuIn1 = ~a;
    fpuIn2 = b ^ 16'h5A5A;
    lat    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic [4:0] exp_fl,
                           input logic [3:0] exp_cc);
    int lat;
    applyStimulus(a, b, lat);
    checkOutput({tag, ".latency"}, 16'(lat), 16'd17);
    checkOutput({tag, ".out"}, fpuOut, exp_res);
    checkOutput({tag, ".flags"}, {11'd0, opStatusFlags}, {11'd0, exp_fl});
    checkOutput({tag, ".cc"}, {12'd0, condCodes}, {12'd0, exp_cc});
    @(posedge clock);
    #1;
    checkOutput({tag, ".donePulse"}, {15'd0, done}, 16'd0);
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fpVal(input logic [15:0] h);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    return (1.0 + $itor(m) / 1024.0) * pow2(e - 15);
  endfunction

  task automatic refDiv(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [4:0] fl, output logic [3:0] cc);
    logic s;
    real  x, m, fl_r, fr;
    int   ex, r, be;
    logic inx;
    s  = a[15] ^ b[15];
    x  = fpVal(a) / fpVal(b);
    ex = 0;
    while (x >= 2.0) begin x = x / 2.0; ex++; end
    while (x < 1.0)  begin x = x * 2.0; ex--; end
    m    = x * 1024.0;
    fl_r = $floor(m);
    fr   = m - fl_r;
    r    = $rtoi(fl_r);
    inx  = (fr != 0.0);
    if (fr > 0.5) r++;
    else if (fr == 0.5 && (r % 2) == 1) r++;
    if (r == 2048) begin r = 1024; ex++; end
    be = ex + 15;
    if (be >= 31) begin
      res = {s, 5'h1F, 10'd0};
      fl  = 5'b00101;
    end else if (be <= 0) begin
      res = {s, 15'd0};
      fl  = 5'b00011;
    end else begin
      res = {s, be[4:0], r[9:0]};
      fl  = {4'b0000, inx};
    end
    cc = {res[14:0] == 15'd0, res[15], 1'b0, fl[2]};
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb, eres;
    logic [4:0]  efl;
    logic [3:0]  ecc;
    int          done_cnt, first_done, second_done;

    reset  = 1'b0;
    start  = 1'b0;
    fpuIn1 = 16'h0000;
    fpuIn2 = 16'h0000;
    #23;
    checkOutput("reset.out", fpuOut, 16'h0000);
    checkOutput("reset.done", {15'd0, done}, 16'd0);
    checkOutput("reset.cc", {12'd0, condCodes}, 16'd0);
    checkOutput("reset.flags", {11'd0, opStatusFlags}, 16'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].cc);
    end

    // Result must hold while idle.
    repeat (5) @(posedge clock);
    #1;
    checkOutput("hold.out", fpuOut, 16'h7E00);
    checkOutput("hold.flags", {11'd0, opStatusFlags}, 16'h0010);

    // Reset while the divide is in flight discards the operation.
    @(negedge clock);
    fpuIn1 = 16'h4200;
    fpuIn2 = 16'h4000;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midReset.out", fpuOut, 16'h0000);
    checkOutput("midReset.done", {15'd0, done}, 16'd0);
    checkOutput("midReset.flags", {11'd0, opStatusFlags}, 16'd0);
    checkOutput("midReset.cc", {12'd0, condCodes}, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    runVector("afterReset", 16'h3C00, 16'h4000, 16'h3800, 5'h00, 4'h0);

    // start held high: one op per IDLE entry, accepted at edges 0 and 19.
    @(negedge clock);
    fpuIn1 = 16'h4200;
    fpuIn2 = 16'h4000;
    start  = 1'b1;
    @(posedge clock);
    #1;
    done_cnt    = 0;
    first_done  = -1;
    second_done = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock);
      #1;
      if (k == 19) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        else second_done = k;
      end
    end
    checkOutput("heldStart.count", 16'(done_cnt), 16'd2);
    checkOutput("heldStart.first", 16'(first_done), 16'd17);
    checkOutput("heldStart.second", 16'(second_done), 16'd36);
    checkOutput("heldStart.out", fpuOut, 16'h3E00);

    for (int i = 0; i < 1000; i++) begin
      ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      refDiv(ra, rb, eres, efl, ecc);
      runVector($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, eres, efl, ecc);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/fpu_div16.md
Name: fpu_div16

Overview:
- Iterative IEEE-754 binary16 divider computing fpuIn1 / fpuIn2.
- Companion to the FP16 multiplier and uses the same start/done handshake, operand types and flag outputs, so both units sit side by side behind the FPU operation dispatcher.
- Uses a radix-2 restoring significand divide, one quotient bit per cycle, with a fixed latency for every operand class.

Parameters:
- QBITS, 14, quotient bits generated by the iteration (11 significand + guard + round + 1 normalisation bit); the sticky bit comes from the final remainder.

Ports:
- clock  input  1  single system clock; everything updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; operands are sampled on the edge where start=1 in IDLE.
- fpuIn1  input  16 (fp16_t)  dividend.
- fpuIn2  input  16 (fp16_t)  divisor.
- fpuOut  output  16 (fp16_t)  quotient; holds its value until the next accepted start.
- done  output  1  one-cycle pulse; fpuOut and the flags are valid while done=1.
- condCodes  output  4 (condCode_t)  {Z,N,C,V}.
- opStatusFlags  output  5 (opStatusFlag_t)  {invalid, divByZero, overflow, underflow, inexact}.

Behaviour:
- Reset (reset=0, at any time, including mid-operation):
  - State goes to IDLE immediately; counter cleared.
  - fpuOut=0000, done=0, condCodes=0, opStatusFlags=0.
  - Any in-flight result is discarded.
- States:
  - IDLE -(start)-> UNPACK -> DIVIDE (QBITS cycles) -> NORM -> ROUND -> DONE -> IDLE.
  - DONE lasts exactly one cycle, with done=1.
- Latency is fixed: if start is sampled at edge 0, done=1 during the cycle after edge QBITS+3 (17 for the default). Special cases take the same path with the divide result ignored.
- start is ignored outside IDLE.
- A start asserted during DONE is not accepted. The first edge that can accept a new start is the one at which state is IDLE.
- UNPACK:
  - Captures signs, exponents and significands with the hidden bit.
  - Subnormal inputs are flushed to signed zero; this alone does not set inexact.
  - Result sign = s1 XOR s2.
  - Biased exponent e = e1 - e2 + 15, held in a signed 7-bit register.
- DIVIDE: restoring divide of 11-bit significands, giving q = floor(sig1*2^13 / sig2) with q in [2^12, 2^14). The remainder is kept for sticky.
- NORM: if q[13]=0, shift q left 1 and decrement e.
- ROUND:
  - Mantissa = q[12:3], guard = q[2], sticky = q[1] | q[0] | (remainder != 0).
  - Round-to-nearest-even.
  - A mantissa carry-out increments e.
  - inexact = guard | sticky.
- Overflow: if e >= 31 after rounding, the result is signed inf, with overflow=1 and inexact=1.
- Underflow: if e <= 0, the result is flushed to signed zero, with underflow=1 and inexact=1.
- Special operands (priority order):
  - Any NaN input -> 7E00; invalid=1 only if that NaN is signalling.
  - 0/0 or inf/inf -> 7E00, invalid=1.
  - inf/finite -> signed inf.
  - finite nonzero / 0 -> signed inf, divByZero=1.
  - finite/inf or 0/nonzero -> signed zero.
  - No other flags are set in these cases.
- condCodes:
  - Z = exponent and mantissa of the result are 0.
  - N = result sign bit, except N=0 for NaN.
  - C = 0.
  - V = the overflow flag.
- Flags and condCodes are registered alongside fpuOut, update only on the transition into DONE, and are never sticky across operations.

Test Plan:
- Reset pulse while in DIVIDE, then start 3C00/4000 -> no done before the new operation; done exactly 17 cycles after the accepted start; fpuOut=3800, flags=00000.
- Exact and inexact cases:
  - 4200/4000 -> 3E00, flags 0.
  - 3C00/4200 -> 3555, inexact=1.
  - C000/3C00 -> C000, N=1.
- Specials:
  - 0000/0000 -> 7E00, invalid.
  - 4000/0000 -> 7C00, divByZero.
  - 7C00/7C00 -> 7E00, invalid.
  - 3C00/7C00 -> 0000, Z=1.
- Overflow/underflow:
  - 7BFF/3800 -> 7C00, overflow+inexact, V=1.
  - 0400/7BFF -> 0000, underflow+inexact, Z=1.
- Handshake:
  - start held high for 20 cycles -> exactly one operation per IDLE entry.
  - Operands changed after the accepted start do not alter the result.
  - fpuOut holds between operations.
- 1000 random normal pairs checked against a real-valued reference rounded to nearest-even with flush-to-zero; fpuOut and all flags must match.
